// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - registered N-input bitwise logic gate with built-in exhaustive sweep engine
//
// Purpose:
//   Bitwise logic gate across NIN operands of WIDTH bits. The operation is selectable
//   (NOR/OR/NAND/AND/XOR/XNOR) and the result travels through a valid-tagged pipeline.
//   A sweep engine can apply every one of the 2^NIN single-bit input combinations,
//   replicated across all WIDTH bits, through the same datapath. It counts how many
//   of those results have bit 0 set, giving a quick integration-level self-check.
//
// Parameters:
//   WIDTH     bits per operand
//   NIN       number of operands (2..8)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   op         in   3   000 NOR, 001 OR, 010 NAND, 011 AND, 100 XOR, 101 XNOR, 11x NOR
//   a          in   NIN*WIDTH operands, operand i = a[i*WIDTH +: WIDTH]
//   valid_in   in   operand set valid this cycle (dropped while busy)
//   y          out  WIDTH bitwise result, holds its value while valid_out = 0
//   valid_out  out  y valid
//   start      in   launch sweep (ignored while busy, wins over valid_in)
//   busy       out  sweep in progress (SWEEP or DRAIN)
//   done       out  one-cycle pulse when the sweep completes
//   ones_cnt   out  NIN+1 number of sweep results with bit 0 set
//
// Configuration:
//   LOGIC_GATE_PIPE_OUT_REG_EN  when defined, adds a second output register stage
//                               (latency 2 instead of 1); DRAIN waits one extra cycle.

module logic_gate_pipe #(
    parameter int WIDTH = 4,
    parameter int NIN   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           op,
    input  logic [NIN*WIDTH-1:0] a,
    input  logic                 valid_in,
    output logic [WIDTH-1:0]     y,
    output logic                 valid_out,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [NIN:0]         ones_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_hold_q, op_hold_d;
    logic [NIN-1:0]       pat_q, pat_d;
    logic [NIN:0]         ones_q, ones_d;
    logic                 done_q, done_d;

    // Pipeline injection point: either the external operand set or a sweep pattern.
    logic                 inj_valid;
    logic                 inj_tag;
    logic [2:0]           inj_op;
    logic [NIN*WIDTH-1:0] inj_a;
    logic [WIDTH-1:0]     inj_y;

    // Reductions across all operands, bit by bit.
    logic [WIDTH-1:0]     and_r;
    logic [WIDTH-1:0]     or_r;
    logic [WIDTH-1:0]     xor_r;

    // First pipeline stage.
    logic                 s1_valid_q;
    logic                 s1_tag_q;
    logic [WIDTH-1:0]     s1_y_q;

    // Final-stage view of the pipeline, plus whether a sweep result is still
    // sitting in a stage ahead of the final one.
    logic                 out_valid;
    logic                 out_tag;
    logic [WIDTH-1:0]     out_y;
    logic                 tag_inflight;

    // ------------------------------------------------------------------
    // Injection mux. In IDLE a coincident start claims the cycle, so the
    // operand set presented alongside it is dropped. Nothing external is
    // accepted while the sweep engine owns the pipeline.
    // ------------------------------------------------------------------
    always_comb begin
        inj_valid = 1'b0;
        inj_tag   = 1'b0;
        inj_op    = op;
        inj_a     = a;
        if (state_q == ST_SWEEP) begin
            inj_valid = 1'b1;
            inj_tag   = 1'b1;
            inj_op    = op_hold_q;
            for (int i = 0; i < NIN; i++) begin
                inj_a[i*WIDTH +: WIDTH] = {WIDTH{pat_q[i]}};
            end
        end else if (state_q == ST_IDLE) begin
            inj_valid = valid_in && !start;
        end
    end

    // ------------------------------------------------------------------
    // Gate datapath
    // ------------------------------------------------------------------
    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int i = 0; i < NIN; i++) begin
            and_r = and_r & inj_a[i*WIDTH +: WIDTH];
            or_r  = or_r  | inj_a[i*WIDTH +: WIDTH];
            xor_r = xor_r ^ inj_a[i*WIDTH +: WIDTH];
        end
        case (inj_op)
            3'b001:  inj_y = or_r;
            3'b010:  inj_y = ~and_r;
            3'b011:  inj_y = and_r;
            3'b100:  inj_y = xor_r;
            3'b101:  inj_y = ~xor_r;
            default: inj_y = ~or_r;     // 000 and the unused codes 110/111
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1. The data register only loads on a valid entry so the
    // result holds across bubbles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= 1'b0;
            s1_y_q     <= '0;
        end else begin
            s1_valid_q <= inj_valid;
            s1_tag_q   <= inj_valid & inj_tag;
            if (inj_valid) begin
                s1_y_q <= inj_y;
            end
        end
    end

`ifdef LOGIC_GATE_PIPE_OUT_REG_EN
    logic             s2_valid_q;
    logic             s2_tag_q;
    logic [WIDTH-1:0] s2_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_tag_q   <= 1'b0;
            s2_y_q     <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_tag_q   <= s1_tag_q;
            if (s1_valid_q) begin
                s2_y_q <= s1_y_q;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_tag      = s2_tag_q;
    assign out_y        = s2_y_q;
    assign tag_inflight = s1_tag_q;
`else
    assign out_valid    = s1_valid_q;
    assign out_tag      = s1_tag_q;
    assign out_y        = s1_y_q;
    assign tag_inflight = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_hold_q <= 3'b000;
            pat_q     <= '0;
            ones_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_hold_q <= op_hold_d;
            pat_q     <= pat_d;
            ones_q    <= ones_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Sweep results are counted as they leave the final
    // stage. DRAIN ends on the edge where the last tagged result leaves,
    // so that edge also delivers the final count. done is registered so it
    // is seen in the first IDLE cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_hold_d = op_hold_q;
        pat_d     = pat_q;
        ones_d    = ones_q;
        done_d    = 1'b0;

        if (out_valid && out_tag && out_y[0]) begin
            ones_d = ones_q + (NIN+1)'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SWEEP;
                    op_hold_d = op;
                    pat_d     = '0;
                    ones_d    = '0;
                end
            end
            ST_SWEEP: begin
                // Increment wraps to zero exactly as the last pattern is injected.
                pat_d = pat_q + NIN'(1);
                if (pat_q == '1) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tag_inflight) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        ones_cnt  = ones_q;
        y         = out_y;
        valid_out = out_valid;
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - self-checking bench for logic_gate_pipe

module tb_logic_gate_pipe;

    localparam int W = 4;
    localparam int N = 2;
`ifdef LOGIC_GATE_PIPE_OUT_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int NSLOT = 4096;

    logic           clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [2:0]     op;
    logic [N*W-1:0] a;
    logic           valid_in;
    logic [W-1:0]   y;
    logic           valid_out;
    logic           start;
    logic           busy;
    logic           done;
    logic [N:0]     ones_cnt;

    logic [2:0]     op3;
    logic [3*W-1:0] a3;
    logic           valid_in3;
    logic [W-1:0]   y3;
    logic           valid_out3;
    logic           start3;
    logic           busy3;
    logic           done3;
    logic [3:0]     ones_cnt3;

    logic_gate_pipe #(.WIDTH(W), .NIN(N)) dut (
        .clk(clk), .rst(rst), .op(op), .a(a), .valid_in(valid_in),
        .y(y), .valid_out(valid_out), .start(start), .busy(busy),
        .done(done), .ones_cnt(ones_cnt)
    );

    logic_gate_pipe #(.WIDTH(W), .NIN(3)) dut3 (
        .clk(clk), .rst(rst), .op(op3), .a(a3), .valid_in(valid_in3),
        .y(y3), .valid_out(valid_out3), .start(start3), .busy(busy3),
        .done(done3), .ones_cnt(ones_cnt3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Expected output per cycle index (cycle = number of rising edges so far).
    bit           ex_known [NSLOT];
    bit           ex_v     [NSLOT];
    bit           ex_r     [NSLOT];
    logic [W-1:0] ex_y     [NSLOT];
    logic [W-1:0] last_y = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: per bit, count how many operands have it set and decide from the count.
    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [N*W-1:0] v);
        logic [W-1:0] r;
        int c;
        r = '0;
        for (int b = 0; b < W; b++) begin
            c = 0;
            for (int i = 0; i < N; i++) c += int'(v[i*W+b]);
            case (o)
                3'd1:    r[b] = (c > 0);
                3'd2:    r[b] = (c != N);
                3'd3:    r[b] = (c == N);
                3'd4:    r[b] = (c % 2 == 1);
                3'd5:    r[b] = (c % 2 == 0);
                default: r[b] = (c == 0);
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (cyc < NSLOT && ex_known[cyc]) begin
            chk("valid_out", valid_out, ex_v[cyc]);
            if (ex_r[cyc]) begin
                chk("y_reset", y, 0);
                last_y = '0;
            end else if (ex_v[cyc]) begin
                chk("y", y, ex_y[cyc]);
                last_y = ex_y[cyc];
            end else begin
                chk("y_hold", y, last_y);
            end
        end
    end

    // Advance one clock; record what the current inputs should produce L edges later.
    task automatic step(input bit sch, input logic [W-1:0] ye);
        int s;
        if (rst) begin
            for (int k = 1; k <= L; k++) begin
                s = cyc + k;
                ex_known[s] = 1'b1; ex_v[s] = 1'b0; ex_r[s] = 1'b1;
            end
        end else begin
            s = cyc + L;
            if (sch) begin
                ex_known[s] = 1'b1; ex_v[s] = 1'b1; ex_r[s] = 1'b0; ex_y[s] = ye;
            end else if (!ex_known[s]) begin
                ex_known[s] = 1'b1; ex_v[s] = 1'b0; ex_r[s] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] o, input logic [N*W-1:0] v);
        valid_in = 1'b1; op = o; a = v;
        step(1'b1, model(o, v));
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0; start = 1'b0;
        for (int k = 0; k < n; k++) step(1'b0, '0);
    endtask

    task automatic sweep(input logic [2:0] sop, input int exp_ones,
                         input bit col_start_valid, input bit col_busy);
        int c0;
        int nlast;
        int s;
        logic [N*W-1:0] pa;
        c0 = cyc;
        for (int p = 0; p < (1 << N); p++) begin
            for (int i = 0; i < N; i++) pa[i*W +: W] = {W{p[i]}};
            s = c0 + 1 + p + L;
            ex_known[s] = 1'b1; ex_v[s] = 1'b1; ex_r[s] = 1'b0; ex_y[s] = model(sop, pa);
        end
        start = 1'b1; op = sop; valid_in = col_start_valid; a = (N*W)'($urandom);
        step(1'b0, '0);
        nlast = (1 << N) + L + 1;
        for (int j = 1; j <= nlast + 2; j++) begin
            chk("busy", busy, (j < nlast));
            chk("done", done, (j == nlast));
            if (j == 1) chk("ones_clear", ones_cnt, 0);
            if (j >= nlast) chk("ones_cnt", ones_cnt, exp_ones);
            if (col_busy && (j == 2 || j == nlast - 1)) begin
                valid_in = 1'b1; start = 1'b1; op = ~sop; a = (N*W)'($urandom);
            end else begin
                valid_in = 1'b0; start = 1'b0;
            end
            step(1'b0, '0);
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic [W-1:0] ey;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int c0;
        int got;
        tbl[0] = '{3'b000, 4'h5, 4'h3, 4'h8};
        tbl[1] = '{3'b001, 4'h5, 4'h3, 4'h7};
        tbl[2] = '{3'b010, 4'h5, 4'h3, 4'hE};
        tbl[3] = '{3'b011, 4'h5, 4'h3, 4'h1};
        tbl[4] = '{3'b100, 4'h5, 4'h3, 4'h6};
        tbl[5] = '{3'b101, 4'h5, 4'h3, 4'h9};
        tbl[6] = '{3'b111, 4'h5, 4'h3, 4'h8};

        rst = 1'b1; op = '0; a = '0; valid_in = 1'b0; start = 1'b0;
        op3 = '0; a3 = '0; valid_in3 = 1'b0; start3 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) step(1'b0, '0);
        rst = 1'b0;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_y", y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ones_cnt", ones_cnt, 0);

        // Op table, streamed back-to-back.
        for (int i = 0; i < 7; i++) begin
            valid_in = 1'b1; op = tbl[i].op; a = {tbl[i].a1, tbl[i].a0};
            step(1'b1, tbl[i].ey);
        end
        idle(2);

        // Ten consecutive sets with varying op, then a single-cycle gap.
        for (int i = 0; i < 10; i++) send(3'(i), (N*W)'($urandom));
        send(3'b100, 8'h3C);
        idle(1);
        send(3'b001, 8'h12);
        idle(L + 1);

        // Random traffic with bubbles.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) != 0) send(3'($urandom), (N*W)'($urandom));
            else idle(1);
        end
        idle(2);

        // Sweeps, including collisions.
        sweep(3'b000, 1, 1'b0, 1'b0);
        sweep(3'b100, 2, 1'b0, 1'b0);
        sweep(3'b010, 3, 1'b0, 1'b0);
        sweep(3'b101, 2, 1'b0, 1'b0);
        sweep(3'b011, 1, 1'b0, 1'b0);
        sweep(3'b000, 1, 1'b1, 1'b0);
        sweep(3'b100, 2, 1'b0, 1'b1);
        sweep(3'b000, 1, 1'b1, 1'b1);

        // Reset for two cycles in the middle of traffic.
        for (int i = 0; i < 5; i++) send(3'($urandom), (N*W)'($urandom));
        rst = 1'b1;
        valid_in = 1'b1; a = (N*W)'($urandom);
        step(1'b0, '0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ones_cnt", ones_cnt, 0);
        step(1'b0, '0);
        rst = 1'b0;
        valid_in = 1'b1; op = 3'b000; a = '0;
        step(1'b1, 4'hF);
        idle(L + 2);

        // Run a sweep so ones_cnt is nonzero, then reset during the next one at E2.
        sweep(3'b010, 3, 1'b0, 1'b0);
        c0 = cyc;
        ex_known[c0+1+L] = 1'b1; ex_v[c0+1+L] = 1'b1; ex_r[c0+1+L] = 1'b0; ex_y[c0+1+L] = 4'hF;
        start = 1'b1; op = 3'b000; valid_in = 1'b0;
        step(1'b0, '0);
        start = 1'b0;
        chk("rstsweep_busy_before", busy, 1);
        step(1'b0, '0);
        rst = 1'b1;
        step(1'b0, '0);
        rst = 1'b0;
        chk("rstsweep_busy", busy, 0);
        chk("rstsweep_done", done, 0);
        chk("rstsweep_ones_cnt", ones_cnt, 0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0);
            chk("rstsweep_no_done", done, 0);
        end
        sweep(3'b000, 1, 1'b0, 1'b0);

        // Three-operand instance: AND sweep has exactly one asserted result.
        c0 = cyc;
        got = -1;
        start3 = 1'b1; op3 = 3'b011;
        step(1'b0, '0);
        start3 = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            if (done3 && got < 0) got = j;
            step(1'b0, '0);
        end
        chk("nin3_done_cycle", got, 8 + L + 1);
        chk("nin3_ones_cnt", ones_cnt3, 1);
        chk("nin3_busy", busy3, 0);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

- Parametrised, registered N-input, W-bit bitwise logic gate.
- Replaces the single-bit combinational NOR cell with a selectable-op datapath: NOR/OR/NAND/AND/XOR/XNOR, valid-tagged pipeline.
- Built-in exhaustive sweep engine applies every input combination internally and counts asserted results. Used for self-check at integration level.
- Sits between operand registers and downstream consumers in the logic-primitive library.

## Interface
Parameters:
- `WIDTH`, 4: bits per operand.
- `NIN`, 2: number of operands, 2..8.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 3: 000 NOR, 001 OR, 010 NAND, 011 AND, 100 XOR, 101 XNOR, 110/111 treated as NOR.
- `a` in NIN*WIDTH: operands; operand i = `a[i*WIDTH +: WIDTH]`.
- `valid_in` in 1: operand set valid this cycle.
- `y` out WIDTH: bitwise result across all NIN operands.
- `valid_out` out 1: `y` valid.
- `start` in 1: launch sweep (single-cycle pulse).
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse, sweep complete.
- `ones_cnt` out NIN+1: sweep patterns whose result bit 0 was 1.

## Operation
- Normal mode (IDLE): on each edge with `valid_in`=1, `op` and `a` are captured into the pipeline. `y`/`valid_out` appear L cycles later.
- Bubbles propagate as `valid_out`=0; `y` holds its last value when invalid.
- XOR/XNOR are reductions over all NIN operands (odd parity / even parity per bit).
- FSM states:
  - IDLE -> SWEEP on `start`=1. Captures `op` into a held register and clears `ones_cnt` and the pattern counter `pat` (NIN bits).
  - SWEEP: each cycle injects pattern `pat`, with operand i = {WIDTH{pat[i]}}, using the held op. `pat` increments each cycle. After pattern 2^NIN-1 is injected -> DRAIN.
  - DRAIN: waits until all sweep-tagged results have left the pipeline. Then -> IDLE with `done`=1 for one cycle.
- Each pipeline entry carries a sweep tag bit.
  - Every tagged `valid_out` with `y[0]`=1 increments `ones_cnt`.
  - `ones_cnt` holds its value after `done` until the next `start` or `rst`.
- Sweep outputs are also presented on `y`/`valid_out`.
- `busy`=1 in SWEEP and DRAIN.
- `valid_in` while `busy`=1 is dropped, not queued.
- `start` while `busy`=1 is ignored.
- `start` and `valid_in` in the same IDLE cycle: the sweep wins and the operand set is dropped.
- `pat` wraps from 2^NIN-1 to 0 only at sweep exit.
- `ones_cnt` max value is 2^NIN, which fits in NIN+1 bits without overflow.

## Timing
- Reset values: `y`=0, `valid_out`=0, `busy`=0, `done`=0, `ones_cnt`=0. FSM goes to IDLE and all pipeline valids and tags are cleared.
- Latency L = 1 edge by default (2 with the configuration macro).
- `busy` rises in the cycle after the `start` edge.
- For the sweep, count `start` edge = E0:
  - pattern p enters the pipeline on edge E(p+1);
  - `done` is high for the cycle following edge E(2^NIN + L);
  - `busy` falls in that same cycle;
  - `ones_cnt` is final when `done`=1.
- `rst` mid-sweep: immediate return to IDLE. `done` is not pulsed and `ones_cnt`=0.
- Throughput: one operand set per cycle in normal mode.

## Configuration
- `LOGIC_GATE_PIPE_OUT_REG_EN` defined:
  - adds a second output register stage, L=2;
  - valid, tag and `y` all move together;
  - DRAIN is extended by one cycle.
- Not defined: single stage, L=1.

## Test plan
- Reset: assert `rst` 2 cycles mid-traffic -> all outputs 0 on the next cycle; then `valid_in` with `a`={0x0,0x0}, `op`=000 -> `y`=0xF, `valid_out`=1 exactly L cycles later.
- Op sweep, NIN=2, WIDTH=4: a0=0x5, a1=0x3. Expected `y` per op:
  - NOR -> 0x8
  - OR -> 0x7
  - NAND -> 0xE
  - AND -> 0x1
  - XOR -> 0x6
  - XNOR -> 0x9
  - `op`=111 -> 0x8
- Back-to-back streaming: 10 consecutive valid sets with varying `op` -> 10 consecutive `valid_out` in order. A one-cycle `valid_in` gap -> one-cycle `valid_out` gap.
- Sweep NOR, NIN=2: `start` with `op`=000 -> 4 tagged outputs y=0xF,0x0,0x0,0x0; `done` after E(4+L); `ones_cnt`=1. With `op`=100 -> `ones_cnt`=2. With NIN=3 and `op`=011 -> `ones_cnt`=1.
- Collisions: `start` together with `valid_in` -> operand dropped. `valid_in` and a second `start` during `busy` -> ignored; `ones_cnt` unchanged from the isolated-sweep value.
- Reset mid-sweep at E2 -> `busy`=0, no `done` pulse, `ones_cnt`=0. A new `start` then completes normally.
